// File: rtl/evenodd_seq_checker.sv
// Receive-side monitor for the 3-bit even/odd counter: predicts the next counter
// value, flags match/mismatch one cycle later, counts errors and latches FAULT.
module evenodd_seq_checker #(
  parameter int ERR_LIMIT = 3,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mon_en,
  input  logic                oe,
  input  logic [2:0]          cnt_in,
  input  logic                clr_fault,
  output logic [2:0]          exp_out,
  output logic                exp_valid,
  output logic                match,
  output logic                mismatch,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_TRACK = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT      = 4'(ERR_LIMIT);
  localparam logic [3:0] CONSEC_MAX = 4'hF;

  state_t              state_q, state_d;
  logic [2:0]          exp_q, exp_d;
  logic                match_q, match_d;
  logic                mismatch_q, mismatch_d;
  logic [ERRCNT_W-1:0] err_q, err_d;
  logic [3:0]          consec_q, consec_d;

  // Golden successor of counter value c under select o.
  function automatic logic [2:0] nxt(input logic [2:0] c, input logic o);
    logic [2:0] r;
    if (o) begin
      if (!c[0])          r = c + 3'd1;
      else if (c == 3'd7) r = 3'd0;
      else                r = c + 3'd2;
    end else begin
      if (!c[0]) r = c + 3'd2;
      else       r = c + 3'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_q;
    consec_d   = consec_q;

    if (!mon_en) begin
      state_d  = S_IDLE;
      exp_d    = 3'd0;
      consec_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HUNT;
        S_HUNT: begin
          exp_d   = nxt(cnt_in, oe);
          state_d = S_TRACK;
        end
        S_TRACK, S_FAULT: begin
          // An unknown cnt_in makes the equality unknown, which falls to the mismatch branch.
          if (cnt_in == exp_q) begin
            match_d  = 1'b1;
            consec_d = 4'd0;
          end else begin
            mismatch_d = 1'b1;
            if (err_q != {ERRCNT_W{1'b1}}) err_d = err_q + ERRCNT_W'(1);
            if (consec_q != CONSEC_MAX)     consec_d = consec_q + 4'd1;
          end
          // Re-seed from the observed value so one glitch costs a single error.
          exp_d = nxt(cnt_in, oe);
          if (state_q == S_FAULT && clr_fault) begin
            state_d  = S_HUNT;
            consec_d = 4'd0;
          end else if (consec_d >= LIMIT) begin
            state_d = S_FAULT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= 3'd0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      consec_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      consec_q   <= consec_d;
    end
  end

  assign exp_out   = exp_q;
  assign exp_valid = (state_q == S_TRACK) || (state_q == S_FAULT);
  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_evenodd_seq_checker.sv
// Directed bench for evenodd_seq_checker: a reference model pushes expected
// outputs per edge into a queue, popped and compared just after that edge.
module tb_evenodd_seq_checker;

  logic       clk = 1'b0;
  logic       rst, mon_en, oe, clr_fault;
  logic [2:0] cnt_in;
  logic [2:0] exp_out;
  logic       exp_valid, match, mismatch, fault;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  evenodd_seq_checker #(.ERR_LIMIT(3), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .oe(oe), .cnt_in(cnt_in),
    .clr_fault(clr_fault), .exp_out(exp_out), .exp_valid(exp_valid),
    .match(match), .mismatch(mismatch), .err_cnt(err_cnt), .fault(fault)
  );

  typedef struct {
    logic [2:0] eo;
    logic       ev;
    logic       m;
    logic       mm;
    logic [7:0] ec;
    logic       f;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int nstep  = 0;
  int match_seen = 0;
  int mism_seen  = 0;

  // Successor tables written out by hand from the counter's sequence rules.
  logic [2:0] odd_t  [8] = '{3'd1, 3'd3, 3'd3, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0};
  logic [2:0] even_t [8] = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd6, 3'd6, 3'd0, 3'd0};

  // Reference model state: 0 idle, 1 hunt, 2 track, 3 fault.
  int         m_st = 0;
  logic [2:0] m_exp = 3'd0;
  int         m_consec = 0;
  int         m_err = 0;
  logic       m_m = 1'b0, m_mm = 1'b0;
  logic [2:0] c = 3'd0;

  function automatic logic [2:0] gold(input logic [2:0] v, input logic o);
    return o ? odd_t[v] : even_t[v];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic o,
                            input logic [2:0] ci, input logic clr);
    exp_t e;
    m_m = 1'b0;
    m_mm = 1'b0;
    if (r) begin
      m_st = 0; m_exp = 3'd0; m_err = 0; m_consec = 0;
    end else if (!en) begin
      m_st = 0; m_exp = 3'd0; m_consec = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      m_exp = gold(ci, o);
      m_st = 2;
    end else begin
      m_m  = (ci == m_exp);
      m_mm = !m_m;
      if (m_mm) begin
        if (m_err < 255) m_err++;
        m_consec++;
      end else begin
        m_consec = 0;
      end
      m_exp = gold(ci, o);
      if (m_st == 3 && clr) begin
        m_st = 1; m_consec = 0;
      end else if (m_consec >= 3) begin
        m_st = 3;
      end
    end
    e.eo = m_exp; e.ev = (m_st >= 2); e.m = m_m; e.mm = m_mm;
    e.ec = 8'(m_err); e.f = (m_st == 3);
    sbq.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic o,
                      input logic [2:0] ci, input logic clr, input string tag);
    exp_t e;
    rst = r; mon_en = en; oe = o; cnt_in = ci; clr_fault = clr;
    model_edge(r, en, o, ci, clr);
    @(posedge clk);
    #1;
    nstep++;
    e = sbq.pop_front();
    $display("step %0d %s: rst=%0b en=%0b oe=%0b cnt_in=%0d clr=%0b -> exp_out=%0d v=%0b m=%0b mm=%0b err=%0d fault=%0b",
             nstep, tag, r, en, o, ci, clr, exp_out, exp_valid, match, mismatch, err_cnt, fault);
    if (e.ev) check({tag, ".exp_out"}, 32'(exp_out), 32'(e.eo));
    check({tag, ".exp_valid"}, 32'(exp_valid), 32'(e.ev));
    check({tag, ".match"},     32'(match),     32'(e.m));
    check({tag, ".mismatch"},  32'(mismatch),  32'(e.mm));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(e.ec));
    check({tag, ".fault"},     32'(fault),     32'(e.f));
    if (match === 1'b1) match_seen++;
    if (mismatch === 1'b1) mism_seen++;
  endtask

  // Run a healthy counter chain for n edges with a fixed select.
  task automatic run(input logic o, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, o, c, 1'b0, tag);
      c = gold(c, o);
    end
  endtask

  // Drive a value guaranteed to differ from the pending prediction.
  task automatic bad(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, m_exp ^ 3'd1, 1'b0, tag);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "reset");
    c = 3'd0; match_seen = 0; mism_seen = 0;
  endtask

  initial begin
    rst = 1'b1; mon_en = 1'b0; oe = 1'b0; cnt_in = 3'd0; clr_fault = 1'b0;
    do_reset();
    do_reset();
    check("rst.exp_out",   32'(exp_out),   32'd0);
    check("rst.exp_valid", 32'(exp_valid), 32'd0);
    check("rst.err_cnt",   32'(err_cnt),   32'd0);
    check("rst.fault",     32'(fault),     32'd0);

    // Odd chain: idle->hunt, hunt capture, then four compares.
    run(1'b1, 6, "t1_odd");
    check("t1.match_count",    32'(match_seen), 32'd4);
    check("t1.mismatch_count", 32'(mism_seen),  32'd0);

    // Even chain from 0.
    step(1'b0, 1'b0, 1'b0, c, 1'b0, "t2_off");
    check("t2.off_valid", 32'(exp_valid), 32'd0);
    c = 3'd0; match_seen = 0;
    run(1'b0, 7, "t2_even");
    check("t2.match_count", 32'(match_seen), 32'd5);

    // Alternating select walks 0..7 including 6/oe=1 -> 7 and 7/oe=0 -> 0.
    step(1'b0, 1'b0, 1'b0, c, 1'b0, "t3_off");
    c = 3'd0; match_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0), c, 1'b0, "t3_alt");
      c = gold(c, (i % 2 == 0));
    end
    check("t3.match_count", 32'(match_seen), 32'd10);
    check("t3.err_cnt",     32'(err_cnt),    32'd0);

    // Single glitch: 4 where 3 is expected, then the chain continues.
    do_reset();
    run(1'b1, 2, "t4_pre");
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, "t4_glitch");
    check("t4.glitch_mismatch", 32'(mismatch), 32'd1);
    c = gold(3'd3, 1'b1);
    run(1'b1, 3, "t4_post");
    check("t4.err_cnt",        32'(err_cnt),   32'd1);
    check("t4.fault",          32'(fault),     32'd0);
    check("t4.mismatch_count", 32'(mism_seen), 32'd1);

    // Three consecutive errors -> FAULT, then clr_fault (with a mismatch on the same edge).
    do_reset();
    run(1'b1, 2, "t5_pre");
    bad(2, "t5_bad");
    check("t5.fault_early", 32'(fault), 32'd0);
    bad(1, "t5_bad3");
    check("t5.fault",   32'(fault),   32'd1);
    check("t5.err_cnt", 32'(err_cnt), 32'd3);
    c = 3'd2;
    step(1'b0, 1'b1, 1'b1, m_exp ^ 3'd2, 1'b1, "t5_clr");
    check("t5.fault_cleared", 32'(fault),     32'd0);
    check("t5.hunt_valid",    32'(exp_valid), 32'd0);
    check("t5.err_kept",      32'(err_cnt),   32'd4);
    run(1'b1, 3, "t5_resume");
    check("t5.resume_valid", 32'(exp_valid), 32'd1);

    // Reset in FAULT with five errors.
    do_reset();
    run(1'b1, 2, "t6_pre");
    bad(5, "t6_bad");
    check("t6.err5", 32'(err_cnt), 32'd5);
    step(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, "t6_rst");
    check("t6.rst_err",   32'(err_cnt),   32'd0);
    check("t6.rst_fault", 32'(fault),     32'd0);
    check("t6.rst_valid", 32'(exp_valid), 32'd0);
    check("t6.rst_mm",    32'(mismatch),  32'd0);

    // mon_en low mid-TRACK holds err_cnt.
    c = 3'd0;
    run(1'b1, 4, "t6_track");
    bad(1, "t6_bad1");
    step(1'b0, 1'b0, 1'b1, c, 1'b0, "t6_off");
    check("t6.off_valid", 32'(exp_valid), 32'd0);
    check("t6.off_err",   32'(err_cnt),   32'd1);

    // mon_en low beats clr_fault in FAULT.
    run(1'b1, 2, "t7_pre");
    bad(3, "t7_bad");
    step(1'b0, 1'b0, 1'b1, c, 1'b1, "t7_off_clr");
    check("t7.fault",  32'(fault),     32'd0);
    check("t7.valid",  32'(exp_valid), 32'd0);
    check("t7.err",    32'(err_cnt),   32'd4);

    // Saturation of the error counter.
    do_reset();
    run(1'b1, 2, "t8_pre");
    bad(260, "t8_sat");
    check("t8.err_sat",  32'(err_cnt),  32'd255);
    check("t8.mm_pulse", 32'(mismatch), 32'd1);
    check("t8.match",    32'(match),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
